// File: rtl/noc_xbar_pkg.sv
// Shared definitions for the crossbar allocator: state encoding, select width derivation
// and packed destination field extraction.
package noc_xbar_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } xbar_state_e;

  // Upper bounds for the generic destination extractor (256 ports max).
  localparam int unsigned MaxSelW = 8;
  localparam int unsigned MaxDstW = 2048;

  function automatic int unsigned sel_width(input int unsigned port_n);
    return (port_n < 2) ? 1 : $clog2(port_n);
  endfunction

  // Field idx of a packed destination bus, zero-extended to MaxSelW bits.
  function automatic logic [MaxSelW-1:0] dst_field(input logic [MaxDstW-1:0] dst,
                                                   input int unsigned idx,
                                                   input int unsigned sel_w);
    logic [MaxSelW-1:0] mask;
    mask = (MaxSelW'(1) << sel_w) - MaxSelW'(1);
    return MaxSelW'(dst >> (idx * sel_w)) & mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester after ptr_i (modulo PORT_N)
// wins, reported both one-hot and as an index.
module rr_arbiter #(
  parameter int unsigned PORT_N = 5,
  parameter int unsigned SEL_W  = 3
) (
  input  logic [PORT_N-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [PORT_N-1:0] grant_o,
  output logic [SEL_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [PORT_N-1:0] upper;

  always_comb begin
    for (int unsigned i = 0; i < PORT_N; i++) begin
      upper[i] = req_i[i] && (i > 32'(ptr_i));
    end

    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;

    // Requesters above the pointer take precedence; otherwise wrap to the lowest index.
    for (int unsigned i = 0; i < PORT_N; i++) begin
      if (!valid_o && upper[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = SEL_W'(i);
        valid_o    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < PORT_N; i++) begin
      if (!valid_o && req_i[i]) begin
        grant_o[i] = 1'b1;
        idx_o      = SEL_W'(i);
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crossbar_rr_allocator.sv
// Packet-level round-robin crossbar allocator: locks one input/output path per packet and
// strobes grant/out_valid for every flit until the tail has crossed.
module crossbar_rr_allocator
  import noc_xbar_pkg::*;
#(
  parameter int unsigned  PORT_N = 5,
  localparam int unsigned SEL_W  = sel_width(PORT_N)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PORT_N-1:0]       req_i,
  input  logic [PORT_N*SEL_W-1:0] dst_i,
  input  logic [PORT_N-1:0]       last_i,
  input  logic [PORT_N-1:0]       out_ready_i,
  output logic [SEL_W-1:0]        mux_in_sel_o,
  output logic [SEL_W-1:0]        mux_out_sel_o,
  output logic [PORT_N-1:0]       grant_o,
  output logic [PORT_N-1:0]       out_valid_o,
  output logic                    busy_o
);

  localparam logic [SEL_W:0]   PortLimit = (SEL_W + 1)'(PORT_N);
  localparam logic [SEL_W-1:0] PtrReset  = SEL_W'(PORT_N - 1);

  xbar_state_e       state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  in_sel_q, in_sel_d;
  logic [SEL_W-1:0]  out_sel_q, out_sel_d;

  logic [MaxDstW-1:0] dst_wide;
  logic [PORT_N-1:0]  eligible;
  logic [PORT_N-1:0]  win_onehot;
  logic [SEL_W-1:0]   win_idx;
  logic               win_valid;
  logic [SEL_W-1:0]   win_dst;
  logic               xfer;

  assign dst_wide = MaxDstW'(dst_i);

  // Out-of-range destinations are masked here so they can never win arbitration.
  always_comb begin
    for (int unsigned i = 0; i < PORT_N; i++) begin
      eligible[i] = req_i[i] && ({1'b0, SEL_W'(dst_field(dst_wide, i, SEL_W))} < PortLimit);
    end
  end

  rr_arbiter #(
    .PORT_N (PORT_N),
    .SEL_W  (SEL_W)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (win_onehot),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  assign win_dst = SEL_W'(dst_field(dst_wide, 32'(win_idx), SEL_W));

  assign xfer = (state_q == StLocked) && req_i[in_sel_q] && out_ready_i[out_sel_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    case (state_q)
      StIdle: begin
        if (win_valid) begin
          in_sel_d  = win_idx;
          out_sel_d = win_dst;
          state_d   = StLocked;
        end
      end
      StLocked: begin
        if (xfer && last_i[in_sel_q]) begin
          ptr_d   = in_sel_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      ptr_q     <= PtrReset;
      in_sel_q  <= '0;
      out_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
    end
  end

  // Strobes follow the flit combinationally so they line up with the crossbar data path.
  assign grant_o       = xfer ? (PORT_N'(1) << in_sel_q) : '0;
  assign out_valid_o   = xfer ? (PORT_N'(1) << out_sel_q) : '0;
  assign busy_o        = (state_q == StLocked);
  assign mux_in_sel_o  = in_sel_q;
  assign mux_out_sel_o = out_sel_q;

  grant_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(grant_o) && $onehot0(out_valid_o));
  grant_needs_lock_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (|grant_o) |-> busy_o);
  winner_consistent_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    win_valid |-> (win_onehot == (PORT_N'(1) << win_idx)));

endmodule

// File: tb/tb_crossbar_rr_allocator.sv
// Directed self-checking bench for crossbar_rr_allocator with hand-computed expectations.
module tb_crossbar_rr_allocator;
  import noc_xbar_pkg::*;

  localparam int unsigned PortN = 5;
  localparam int unsigned SelW  = sel_width(PortN);

  logic                   clk;
  logic                   rst_n;
  logic [PortN-1:0]       req;
  logic [PortN*SelW-1:0]  dst;
  logic [PortN-1:0]       last;
  logic [PortN-1:0]       out_ready;
  logic [SelW-1:0]        mux_in_sel;
  logic [SelW-1:0]        mux_out_sel;
  logic [PortN-1:0]       grant;
  logic [PortN-1:0]       out_valid;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;

  crossbar_rr_allocator #(
    .PORT_N (PortN)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req_i         (req),
    .dst_i         (dst),
    .last_i        (last),
    .out_ready_i   (out_ready),
    .mux_in_sel_o  (mux_in_sel),
    .mux_out_sel_o (mux_out_sel),
    .grant_o       (grant),
    .out_valid_o   (out_valid),
    .busy_o        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    last      = '0;
    out_ready = '1;
    #2;
    rst_n     = 1'b1;
  endtask

  function automatic logic [PortN*SelW-1:0] pack_dst(input logic [SelW-1:0] d0,
                                                     input logic [SelW-1:0] d1,
                                                     input logic [SelW-1:0] d2,
                                                     input logic [SelW-1:0] d3,
                                                     input logic [SelW-1:0] d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  initial begin
    int               cnt;
    logic [PortN-1:0] exp_g;

    rst_n     = 1'b0;
    req       = '0;
    dst       = '0;
    last      = '0;
    out_ready = '1;
    #1;
    check_eq("rst_busy", 32'(busy), 32'(1'b0));
    check_eq("rst_grant", 32'(grant), 32'(5'b00000));
    check_eq("rst_out_valid", 32'(out_valid), 32'(5'b00000));
    check_eq("rst_mux_in", 32'(mux_in_sel), 32'(3'd0));
    check_eq("rst_mux_out", 32'(mux_out_sel), 32'(3'd0));
    #12;
    rst_n = 1'b1;
    tick();

    // Reset priority: input 0 first, then input 2
    req  = 5'b00101;
    dst  = pack_dst(3'd1, 3'd1, 3'd1, 3'd1, 3'd1);
    last = '1;
    #1;
    check_eq("prio_idle_busy", 32'(busy), 32'(1'b0));
    check_eq("prio_idle_grant", 32'(grant), 32'(5'b00000));
    tick();
    check_eq("prio_lock0_in", 32'(mux_in_sel), 32'(3'd0));
    check_eq("prio_lock0_out", 32'(mux_out_sel), 32'(3'd1));
    check_eq("prio_lock0_busy", 32'(busy), 32'(1'b1));
    check_eq("prio_lock0_grant", 32'(grant), 32'(5'b00001));
    check_eq("prio_lock0_ov", 32'(out_valid), 32'(5'b00010));
    tick();
    check_eq("prio_bubble_busy", 32'(busy), 32'(1'b0));
    check_eq("prio_bubble_grant", 32'(grant), 32'(5'b00000));
    check_eq("prio_bubble_hold_in", 32'(mux_in_sel), 32'(3'd0));
    tick();
    check_eq("prio_lock2_in", 32'(mux_in_sel), 32'(3'd2));
    check_eq("prio_lock2_grant", 32'(grant), 32'(5'b00100));
    tick();

    // Rotation fairness: everyone requests 1-flit packets to port 4
    do_reset();
    req  = '1;
    dst  = pack_dst(3'd4, 3'd4, 3'd4, 3'd4, 3'd4);
    last = '1;
    tick();
    for (int k = 0; k < 10; k++) begin
      exp_g = PortN'(1) << (k % 5);
      check_eq($sformatf("rot%0d_in", k), 32'(mux_in_sel), 32'(k % 5));
      check_eq($sformatf("rot%0d_grant", k), 32'(grant), 32'(exp_g));
      check_eq($sformatf("rot%0d_ov", k), 32'(out_valid), 32'(5'b10000));
      tick();
      check_eq($sformatf("rot%0d_gap", k), 32'(grant), 32'(5'b00000));
      tick();
    end

    // Multi-flit hold: input 3 four flits to port 0, input 1 waits
    do_reset();
    req  = 5'b01000;
    dst  = pack_dst(3'd2, 3'd2, 3'd2, 3'd0, 3'd2);
    last = '0;
    tick();
    req = 5'b01010;
    cnt = 0;
    for (int f = 1; f <= 4; f++) begin
      if (f == 4) last = 5'b01000;
      #1;
      check_eq($sformatf("hold_f%0d_grant", f), 32'(grant), 32'(5'b01000));
      check_eq($sformatf("hold_f%0d_ov", f), 32'(out_valid), 32'(5'b00001));
      check_eq($sformatf("hold_f%0d_in", f), 32'(mux_in_sel), 32'(3'd3));
      if (grant[3]) cnt++;
      tick();
    end
    check_eq("hold_bubble_busy", 32'(busy), 32'(1'b0));
    check_eq("hold_bubble_grant", 32'(grant), 32'(5'b00000));
    tick();
    check_eq("hold_next_in", 32'(mux_in_sel), 32'(3'd1));
    check_eq("hold_next_out", 32'(mux_out_sel), 32'(3'd2));
    check_eq("hold_next_grant", 32'(grant), 32'(5'b00010));
    check_eq("hold_pulses", 32'(cnt), 32'(4));

    // Backpressure then requester bubble; a dst change mid-packet is ignored
    do_reset();
    req  = 5'b00100;
    dst  = pack_dst(3'd0, 3'd0, 3'd3, 3'd0, 3'd0);
    last = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        out_ready = 5'b10111;
      end else begin
        out_ready = '1;
        req       = '0;
      end
      dst = pack_dst(3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
      #1;
      check_eq($sformatf("stall%0d_grant", c), 32'(grant), 32'(5'b00000));
      check_eq($sformatf("stall%0d_ov", c), 32'(out_valid), 32'(5'b00000));
      check_eq($sformatf("stall%0d_busy", c), 32'(busy), 32'(1'b1));
      check_eq($sformatf("stall%0d_in", c), 32'(mux_in_sel), 32'(3'd2));
      check_eq($sformatf("stall%0d_out", c), 32'(mux_out_sel), 32'(3'd3));
      tick();
    end
    req  = 5'b00100;
    last = 5'b00100;
    #1;
    check_eq("stall_resume_grant", 32'(grant), 32'(5'b00100));
    check_eq("stall_resume_ov", 32'(out_valid), 32'(5'b01000));
    tick();
    check_eq("stall_done_busy", 32'(busy), 32'(1'b0));

    // Invalid destination never granted
    do_reset();
    req  = 5'b00001;
    dst  = pack_dst(3'd7, 3'd0, 3'd0, 3'd0, 3'd0);
    last = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq($sformatf("inval%0d_busy", c), 32'(busy), 32'(1'b0));
      check_eq($sformatf("inval%0d_grant", c), 32'(grant), 32'(5'b00000));
    end
    req = 5'b00011;
    tick();
    check_eq("inval_skip_in", 32'(mux_in_sel), 32'(3'd1));
    check_eq("inval_skip_out", 32'(mux_out_sel), 32'(3'd0));
    check_eq("inval_skip_grant", 32'(grant), 32'(5'b00010));
    tick();
    req = 5'b00001;
    dst = pack_dst(3'd2, 3'd0, 3'd0, 3'd0, 3'd0);
    tick();
    check_eq("inval_fixed_in", 32'(mux_in_sel), 32'(3'd0));
    check_eq("inval_fixed_out", 32'(mux_out_sel), 32'(3'd2));
    check_eq("inval_fixed_grant", 32'(grant), 32'(5'b00001));

    // Async reset mid-packet; ptr must return to PORT_N-1
    do_reset();
    req  = 5'b00010;
    dst  = pack_dst(3'd0, 3'd3, 3'd0, 3'd0, 3'd0);
    last = 5'b00010;
    tick();
    check_eq("arst_pre_grant", 32'(grant), 32'(5'b00010));
    tick();
    req  = 5'b00100;
    dst  = pack_dst(3'd0, 3'd0, 3'd1, 3'd0, 3'd0);
    last = '0;
    tick();
    check_eq("arst_f1_grant", 32'(grant), 32'(5'b00100));
    tick();
    check_eq("arst_f2_grant", 32'(grant), 32'(5'b00100));
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 32'(busy), 32'(1'b0));
    check_eq("arst_grant", 32'(grant), 32'(5'b00000));
    check_eq("arst_ov", 32'(out_valid), 32'(5'b00000));
    check_eq("arst_mux_in", 32'(mux_in_sel), 32'(3'd0));
    req  = '1;
    dst  = pack_dst(3'd1, 3'd1, 3'd1, 3'd1, 3'd1);
    last = '1;
    #1;
    rst_n = 1'b1;
    tick();
    check_eq("arst_ptr_in", 32'(mux_in_sel), 32'(3'd0));
    check_eq("arst_ptr_grant", 32'(grant), 32'(5'b00001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_rr_allocator.md
# crossbar_rr_allocator

Packet-level round-robin allocator that sequences the shared N-to-N crossbar of a mesh switch, one packet at a time. It picks one requesting input port and its destination output port. It drives the crossbar input/output mux selects and holds the path until the packet's tail flit has been transferred. It sits between the per-port input buffers (request/grant side) and the crossbar plus output links (select/strobe side).

## Interface
- PORT_N, 5, number of switch ports (≥2)
- SEL_W, $clog2(PORT_N), select/destination field width (derived, not overridden)
- clk_i  in  1  switch clock
- rst_ni  in  1  reset; asynchronous, active-low
- req_i  in  PORT_N  input port i holds a flit at buffer head
- dst_i  in  PORT_N*SEL_W  packed destination output port per input; field i at [SEL_W*(i+1)-1 : SEL_W*i]
- last_i  in  PORT_N  head flit of input i is the packet tail
- out_ready_i  in  PORT_N  output port j can accept a flit this cycle
- mux_in_sel_o  out  SEL_W  crossbar input select
- mux_out_sel_o  out  SEL_W  crossbar output select
- grant_o  out  PORT_N  one-hot pop strobe to input buffer; flit transferred this cycle
- out_valid_o  out  PORT_N  one-hot write strobe to output port
- busy_o  out  1  path locked (state LOCKED)

## Operation
- Two states: IDLE and LOCKED. Registers: state, ptr (SEL_W, last served input), in_sel, out_sel (SEL_W each).
- Eligible input i: req_i[i]=1 and dst field i < PORT_N. Inputs with an out-of-range destination are never granted.
- IDLE:
  - If any input is eligible, pick the winner by rotating priority. Search order is ptr+1, ptr+2, … modulo PORT_N; first eligible wins.
  - Load in_sel ← winner and out_sel ← dst of winner; go to LOCKED.
  - grant_o and out_valid_o are 0.
- LOCKED: transfer occurs in any cycle where req_i[in_sel]=1 and out_ready_i[out_sel]=1. In a transfer cycle:
  - grant_o[in_sel]=1 and out_valid_o[out_sel]=1; all other bits are 0.
  - If last_i[in_sel]=1, set ptr ← in_sel and go to IDLE.
- LOCKED with no transfer (requester bubble or output backpressure): stay LOCKED with selects held. Other requesters are not served, so there is no mid-packet preemption.
- dst_i of the locked input is ignored after lock. out_sel is fixed for the whole packet.
- Self-routing (dst == source index) is legal.
- mux selects hold their last value in IDLE.

## Timing
- Reset (asynchronous assert):
  - state=IDLE, ptr=PORT_N-1 (input 0 has first priority), in_sel=0, out_sel=0.
  - grant_o=0, out_valid_o=0, busy_o=0.
  - mux_in_sel_o=0, mux_out_sel_o=0.
- Reset mid-packet aborts the packet. The path is released immediately and no strobes are issued; the remaining flits are re-arbitrated as a new packet.
- Arbitration latency: request seen in IDLE at cycle t → LOCKED and selects valid at t+1 → first transfer earliest at t+1.
- grant_o and out_valid_o are combinational from registered state and sels plus req_i/out_ready_i. They are asserted in the same cycle as the transfer, matching the combinational crossbar path.
- After a tail transfer at cycle t: IDLE at t+1 and the next lock at t+2. Each packet has a 1-cycle arbitration bubble.
- Single-flit packet: last_i=1 on the first transfer; LOCKED for exactly one transfer cycle.
- req_i deasserting while IDLE before the lock is taken: no effect; that cycle's winner is evaluated from current inputs only.

## Structure
- Shared package (noc_xbar_pkg): state encoding (IDLE=0, LOCKED=1), SEL_W derivation, and the dst field extract function. These are reused by the switch top and the bench.
- One sub-module: rr_arbiter. It takes PORT_N request bits and the ptr, and returns a one-hot winner plus its index (combinational, rotating priority). The FSM and select registers stay in crossbar_rr_allocator.

## Test plan
- **Reset/priority:** after reset, req_i=5'b00101, all dst=1 → lock input 0 (mux_in_sel_o=0, mux_out_sel_o=1). After a 1-flit tail, input 2 locks next.
- **Rotation fairness:** all five inputs request continuously with 1-flit packets to port 4. Grant order is 0,1,2,3,4,0, with one grant every 2 cycles.
- **Multi-flit hold:** input 3 sends a 4-flit packet to port 0 while input 1 requests. Input 1 is not granted until the cycle after input 3's tail; grant_o[3] pulses exactly 4 times.
- **Backpressure/bubble:** during a lock, out_ready_i[out_sel]=0 for 3 cycles, then req_i[in_sel]=0 for 2 cycles. There are no strobes in those cycles, selects are unchanged, and busy_o stays 1.
- **Invalid destination:** dst field of input 0 = 7 with PORT_N=5 and req_i=5'b00001. The block stays IDLE and grant_o stays 0; input 0 with dst 2 is then served.
- **Async reset mid-packet:** assert rst_ni low between flits 2 and 3 of a 4-flit packet. busy_o, grant_o and out_valid_o drop immediately (without waiting for a clock edge) and ptr returns to 4.
